// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
// Contents: default sizing, oversampling tick counts, trigger-level encoding and
// a helper that maps a trigger-level select onto an occupancy threshold.
package uart_rx_pkg;

    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_TOUT_BITS = 40;   // 4 characters x 10 bit periods

    localparam int unsigned OSM_TICKS_13  = 13;
    localparam int unsigned OSM_TICKS_16  = 16;

    typedef enum logic [1:0] {
        TrigLvl1        = 2'b00,
        TrigLvl4        = 2'b01,
        TrigLvl8        = 2'b10,
        TrigLvlNearFull = 2'b11
    } trig_lvl_e;

    function automatic int unsigned trig_threshold(input logic [1:0] sel,
                                                   input int unsigned depth);
        case (trig_lvl_e'(sel))
            TrigLvl1:        return 1;
            TrigLvl4:        return 4;
            TrigLvl8:        return 8;
            TrigLvlNearFull: return depth - 2;
            default:         return 1;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// First-word-fall-through FIFO holding 9-bit entries {parity tag, character}.
// Ports:
//   i_pclk, i_presetn  clock, synchronous active-low reset
//   i_flush            empties the FIFO (priority over read/write)
//   i_wr, i_wdata      write strobe and entry
//   i_rd               pop request
//   o_rdata            registered head entry (0 out of reset)
//   o_count            occupancy 0..DEPTH
//   o_empty, o_full    derived from the registered count
//   o_wr_acc, o_rd_acc accepted write / read this cycle
module uart_rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = 4
) (
    input  logic          i_pclk,
    input  logic          i_presetn,
    input  logic          i_flush,
    input  logic          i_wr,
    input  logic [8:0]    i_wdata,
    input  logic          i_rd,
    output logic [8:0]    o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_wr_acc,
    output logic          o_rd_acc
);

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [8:0]    r_head;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW-1:0] w_rd_ptr_d;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = i_rd && !w_empty;
    // A write at full is still taken when a read frees a slot in the same cycle.
    assign w_wr_acc = i_wr && (!w_full || w_rd_acc);
    assign w_rd_ptr_d = w_rd_acc ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge i_pclk) begin
        if (i_presetn && !i_flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (!i_presetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_ptr_d;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head register only moves on traffic so it stays 0 until the first write.
            // Forward the incoming entry when it lands in the next head slot.
            if (w_wr_acc || w_rd_acc) begin
                r_head <= (w_wr_acc && (r_wr_ptr == w_rd_ptr_d)) ? i_wdata
                                                                  : r_mem[w_rd_ptr_d];
            end
        end
    end

    assign o_rdata  = r_head;
    assign o_count  = r_count;
    assign o_empty  = w_empty;
    assign o_full   = w_full;
    assign o_wr_acc = w_wr_acc;
    assign o_rd_acc = w_rd_acc;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between the UART receiver and the register interface.
// Buffers characters with a parity tag, back-pressures the receiver, flags overrun,
// and raises the RX threshold and character-timeout interrupts.
// Ports: pclk/presetn (sync active-low), bclk baud tick, osm_sel oversampling select,
//   rx_data/rx_wr/rx_frame_end/s_parrity_error from the receiver, rx_full_status to it,
//   rd_en/rd_data/rd_perr/rx_empty/rx_count/fifo_flush/rx_trig_lvl from/to registers,
//   int_rx_thr, int_rx_tout, overrun_err/ovr_clr.
// Optional: define UART_RX_STATS_EN to add rx_drop_cnt, a saturating overrun counter.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AW        = 4,
    parameter int unsigned TOUT_BITS = DEF_TOUT_BITS
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          bclk,
    input  logic          osm_sel,
    input  logic [7:0]    rx_data,
    input  logic          rx_wr,
    input  logic          rx_frame_end,
    input  logic          s_parrity_error,
    output logic          rx_full_status,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic          rx_empty,
    output logic [AW:0]   rx_count,
    input  logic          fifo_flush,
    input  logic [1:0]    rx_trig_lvl,
    output logic          int_rx_thr,
    output logic          int_rx_tout,
`ifdef UART_RX_STATS_EN
    output logic [7:0]    rx_drop_cnt,
`endif
    output logic          overrun_err,
    input  logic          ovr_clr
);

    localparam int unsigned IW = $clog2(TOUT_BITS + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TOUT_BITS);

    logic          r_perr_pend;
    logic          r_ovr;
    logic          r_int_thr;
    logic          r_int_tout;
    logic [3:0]    r_tick;
    logic [IW-1:0] r_idle;

    logic          w_tag;
    logic [8:0]    w_head;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [AW:0]   w_count;
    logic [3:0]    w_tick_last;
    logic          w_bit_end;
    logic [IW-1:0] w_idle_d;
    int unsigned   w_thr;
    logic          w_ovr_evt;

    assign w_tag = r_perr_pend | s_parrity_error;

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_pclk    (pclk),
        .i_presetn (presetn),
        .i_flush   (fifo_flush),
        .i_wr      (rx_wr),
        .i_wdata   ({w_tag, rx_data}),
        .i_rd      (rd_en),
        .o_rdata   (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_wr_acc  (w_wr_acc),
        .o_rd_acc  (w_rd_acc)
    );

    // Parity error arrives before the write of its frame; hold it until frame end.
    always_ff @(posedge pclk) begin
        if (!presetn || fifo_flush) r_perr_pend <= 1'b0;
        else if (s_parrity_error)   r_perr_pend <= 1'b1;
        else if (rx_frame_end)      r_perr_pend <= 1'b0;
    end

    assign w_ovr_evt = rx_frame_end && w_full;

    always_ff @(posedge pclk) begin
        if (!presetn)       r_ovr <= 1'b0;
        else if (w_ovr_evt) r_ovr <= 1'b1;
        else if (ovr_clr)   r_ovr <= 1'b0;
    end

`ifdef UART_RX_STATS_EN
    logic [7:0] r_drop;
    always_ff @(posedge pclk) begin
        if (!presetn)                     r_drop <= '0;
        else if (w_ovr_evt)               r_drop <= (r_drop == 8'hFF) ? r_drop : r_drop + 1'b1;
        else if (ovr_clr)                 r_drop <= '0;
    end
    assign rx_drop_cnt = r_drop;
`endif

    assign w_thr = trig_threshold(rx_trig_lvl, DEPTH);

    always_ff @(posedge pclk) begin
        if (!presetn) r_int_thr <= 1'b0;
        else          r_int_thr <= (32'(w_count) >= w_thr);
    end

    // A count left beyond a newly shortened limit runs on to 15 before wrapping.
    assign w_tick_last = osm_sel ? 4'(OSM_TICKS_13 - 1) : 4'(OSM_TICKS_16 - 1);
    assign w_bit_end   = bclk && ((r_tick == w_tick_last) || (r_tick == 4'hF));

    always_ff @(posedge pclk) begin
        if (!presetn || fifo_flush || w_empty) r_tick <= '0;
        else if (bclk)                         r_tick <= w_bit_end ? 4'd0 : r_tick + 1'b1;
    end

    always_comb begin
        w_idle_d = r_idle;
        if (fifo_flush || w_wr_acc || w_rd_acc || w_empty) begin
            w_idle_d = '0;
        end else if (w_bit_end && (r_idle != IDLE_MAX)) begin
            w_idle_d = r_idle + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_idle     <= '0;
            r_int_tout <= 1'b0;
        end else begin
            r_idle <= w_idle_d;
            if (fifo_flush || w_wr_acc || w_rd_acc) r_int_tout <= 1'b0;
            else if (w_idle_d == IDLE_MAX)           r_int_tout <= 1'b1;
        end
    end

    assign rx_full_status = w_full;
    assign rx_empty       = w_empty;
    assign rx_count       = w_count;
    assign rd_data        = w_head[7:0];
    assign rd_perr        = w_head[8];
    assign int_rx_thr     = r_int_thr;
    assign int_rx_tout    = r_int_tout;
    assign overrun_err    = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;

    logic       pclk = 1'b0;
    logic       presetn, bclk, osm_sel, rx_wr, rx_frame_end, s_parrity_error;
    logic [7:0] rx_data;
    logic       rx_full_status, rd_en, rd_perr, rx_empty, fifo_flush;
    logic [7:0] rd_data;
    logic [4:0] rx_count;
    logic [1:0] rx_trig_lvl;
    logic       int_rx_thr, int_rx_tout, overrun_err, ovr_clr;
`ifdef UART_RX_STATS_EN
    logic [7:0] rx_drop_cnt;
`endif

    uart_rx_ctrl dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .bclk            (bclk),
        .osm_sel         (osm_sel),
        .rx_data         (rx_data),
        .rx_wr           (rx_wr),
        .rx_frame_end    (rx_frame_end),
        .s_parrity_error (s_parrity_error),
        .rx_full_status  (rx_full_status),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_perr         (rd_perr),
        .rx_empty        (rx_empty),
        .rx_count        (rx_count),
        .fifo_flush      (fifo_flush),
        .rx_trig_lvl     (rx_trig_lvl),
        .int_rx_thr      (int_rx_thr),
        .int_rx_tout     (int_rx_tout),
`ifdef UART_RX_STATS_EN
        .rx_drop_cnt     (rx_drop_cnt),
`endif
        .overrun_err     (overrun_err),
        .ovr_clr         (ovr_clr)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_strobes();
        rx_wr = 0; rd_en = 0; rx_frame_end = 0; s_parrity_error = 0;
        fifo_flush = 0; ovr_clr = 0; bclk = 0;
    endtask

    // Clock edge, then settle before sampling.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic step();
        tick();
        clr_strobes();
    endtask

    task automatic do_reset();
        clr_strobes();
        presetn = 0;
        tick(); tick();
        presetn = 1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rd;
        logic       fe;
        logic       pe;
        int         cnt;
        logic       chk_head;
        logic [7:0] hd;
        logic       hp;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic rd,
                                input logic fe, input logic pe, input int cnt,
                                input logic ch, input logic [7:0] hd, input logic hp);
        vec_t v;
        v.wr = wr; v.d = d; v.rd = rd; v.fe = fe; v.pe = pe; v.cnt = cnt;
        v.chk_head = ch; v.hd = hd; v.hp = hp;
        return v;
    endfunction

    vec_t vecs [17];

    // Run ticks of the baud clock, checking the timeout fires exactly on tick n.
    task automatic run_tout(input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            bclk = 1;
            tick();
            bclk = 0;
            if (i == n - 1) chk({name, "_before"}, int'(int_rx_tout), 0);
            if (i == n)     chk({name, "_at"}, int'(int_rx_tout), 1);
            tick(); tick();
        end
    endtask

    // Reference model state for the random phase.
    logic [8:0] q [$];
    logic       m_pend, m_ovr, m_thr;
    int         m_drop;

    function automatic int thr_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return DEPTH - 2;
        endcase
    endfunction

    initial begin
        osm_sel = 0; rx_data = 0; rx_trig_lvl = 2'b00;
        do_reset();

        chk("rst_count", int'(rx_count), 0);
        chk("rst_empty", int'(rx_empty), 1);
        chk("rst_full", int'(rx_full_status), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_perr", int'(rd_perr), 0);
        chk("rst_thr", int'(int_rx_thr), 0);
        chk("rst_tout", int'(int_rx_tout), 0);
        chk("rst_ovr", int'(overrun_err), 0);

        //            wr    data    rd    fe    pe    cnt chk   head    perr
        vecs[0]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0);
        vecs[1]  = mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h41, 1'b0);
        vecs[2]  = mk(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 3, 1'b1, 8'h41, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h42, 1'b0);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h43, 1'b0);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0);
        vecs[8]  = mk(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b1);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h55, 1'b1);
        vecs[10] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h55, 1'b1);
        vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1'b1, 8'h55, 1'b1);
        vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'hAA, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        vecs[14] = mk(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h77, 1'b1);
        vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h77, 1'b1);
        vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0);

        foreach (vecs[i]) begin
            rx_wr = vecs[i].wr; rx_data = vecs[i].d; rd_en = vecs[i].rd;
            rx_frame_end = vecs[i].fe; s_parrity_error = vecs[i].pe;
            step();
            chk($sformatf("vec%0d_count", i), int'(rx_count), vecs[i].cnt);
            chk($sformatf("vec%0d_empty", i), int'(rx_empty), int'(vecs[i].cnt == 0));
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d_data", i), int'(rd_data), int'(vecs[i].hd));
                chk($sformatf("vec%0d_perr", i), int'(rd_perr), int'(vecs[i].hp));
            end
        end

        // Fill, overrun, clear, full-boundary read/write, flush.
        for (int i = 0; i < DEPTH; i++) begin
            rx_wr = 1; rx_data = 8'(8'h10 + i);
            step();
        end
        chk("fill_count", int'(rx_count), DEPTH);
        chk("fill_full", int'(rx_full_status), 1);
        chk("fill_head", int'(rd_data), 8'h10);
        rx_wr = 1; rx_data = 8'hEE; step();
        chk("wr_at_full_ignored", int'(rx_count), DEPTH);
        rx_frame_end = 1; step();
        chk("ovr_set", int'(overrun_err), 1);
        ovr_clr = 1; step();
        chk("ovr_clr", int'(overrun_err), 0);
        rx_frame_end = 1; ovr_clr = 1; step();
        chk("ovr_set_wins", int'(overrun_err), 1);
        ovr_clr = 1; step();
        chk("ovr_clr2", int'(overrun_err), 0);
        chk("intact_head", int'(rd_data), 8'h10);
        rx_wr = 1; rx_data = 8'hEF; rd_en = 1; step();
        chk("full_rdwr_count", int'(rx_count), DEPTH);
        chk("full_rdwr_head", int'(rd_data), 8'h11);
        fifo_flush = 1; rx_wr = 1; rx_data = 8'h99; step();
        chk("flush_count", int'(rx_count), 0);
        chk("flush_empty", int'(rx_empty), 1);

        // Threshold at level 4.
        rx_trig_lvl = 2'b01;
        for (int i = 0; i < 4; i++) begin
            rx_wr = 1; rx_data = 8'(i); step();
        end
        chk("thr_same_cycle", int'(int_rx_thr), 0);
        step();
        chk("thr_next_cycle", int'(int_rx_thr), 1);
        rd_en = 1; step();
        chk("thr_pop_lag", int'(int_rx_thr), 1);
        step();
        chk("thr_pop_clear", int'(int_rx_thr), 0);
        fifo_flush = 1; step();
        rx_trig_lvl = 2'b00;

        // Character timeout, 16x then 13x oversampling.
        osm_sel = 0; rx_wr = 1; rx_data = 8'h5A; step();
        run_tout(40 * 16, "tout16");
        rd_en = 1; step();
        chk("tout16_rd_clear", int'(int_rx_tout), 0);
        osm_sel = 1; rx_wr = 1; rx_data = 8'hA5; step();
        run_tout(40 * 13, "tout13");
        fifo_flush = 1; step();
        chk("tout13_flush_clear", int'(int_rx_tout), 0);
        osm_sel = 0;

        // Randomized traffic against a queue model.
        do_reset();
        q.delete(); m_pend = 0; m_ovr = 0; m_thr = 0; m_drop = 0;
        for (int c = 0; c < 600; c++) begin
            logic full_b, rd_ok, wr_ok, tag;
            rx_wr = ($urandom_range(99) < 55);
            rd_en = ($urandom_range(99) < 40);
            rx_frame_end = ($urandom_range(99) < 30);
            s_parrity_error = ($urandom_range(99) < 15);
            fifo_flush = ($urandom_range(99) < 3);
            ovr_clr = ($urandom_range(99) < 10);
            rx_data = 8'($urandom);
            if ($urandom_range(99) < 5) rx_trig_lvl = 2'($urandom);

            full_b = (q.size() == DEPTH);
            m_thr  = (q.size() >= thr_of(rx_trig_lvl));
            tag    = m_pend | s_parrity_error;
            if (rx_frame_end && full_b) begin
                m_ovr = 1;
                if (m_drop < 255) m_drop++;
            end else if (ovr_clr) begin
                m_ovr = 0;
                m_drop = 0;
            end
            if (fifo_flush) begin
                q.delete();
                m_pend = 0;
            end else begin
                rd_ok = rd_en && (q.size() > 0);
                wr_ok = rx_wr && (!full_b || rd_ok);
                if (rd_ok) void'(q.pop_front());
                if (wr_ok) q.push_back({tag, rx_data});
                if (s_parrity_error)   m_pend = 1;
                else if (rx_frame_end) m_pend = 0;
            end
            step();
            chk($sformatf("rnd%0d_count", c), int'(rx_count), q.size());
            chk($sformatf("rnd%0d_full", c), int'(rx_full_status), int'(q.size() == DEPTH));
            chk($sformatf("rnd%0d_ovr", c), int'(overrun_err), int'(m_ovr));
            chk($sformatf("rnd%0d_thr", c), int'(int_rx_thr), int'(m_thr));
            if (q.size() > 0) begin
                chk($sformatf("rnd%0d_head", c), int'({rd_perr, rd_data}), int'(q[0]));
            end
`ifdef UART_RX_STATS_EN
            chk($sformatf("rnd%0d_drop", c), int'(rx_drop_cnt), m_drop);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART receiver and the AHB-Lite register interface.
- Buffers received characters in a DEPTH-entry first-word-fall-through FIFO.
- Tags each character with its parity-error status.
- Drives full back-pressure to the receiver.
- Detects overrun.
- Generates the RX threshold and character-timeout interrupts.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..64
AW, 4, pointer width, log2(DEPTH)
TOUT_BITS, 40, idle bit periods before timeout (4 chars x 10 bits)

Ports:
pclk  in  1  system clock
presetn  in  1  reset, synchronous, active-low
bclk  in  1  baud tick, one pclk wide
osm_sel  in  1  1: 13 ticks/bit, 0: 16 ticks/bit
rx_data  in  8  character from receiver, right-aligned
rx_wr  in  1  write strobe from receiver, one cycle
rx_frame_end  in  1  pulse at end of every stop phase, whether or not written
s_parrity_error  in  1  parity error pulse from receiver, precedes rx_wr of the same frame
rx_full_status  out  1  FIFO full, to receiver
rd_en  in  1  pop request from register interface
rd_data  out  8  head character, valid when rx_empty=0
rd_perr  out  1  parity tag of head entry
rx_empty  out  1  FIFO empty
rx_count  out  AW+1  occupancy, 0..DEPTH
fifo_flush  in  1  synchronous flush
rx_trig_lvl  in  2  threshold select: 00=1, 01=4, 10=8, 11=DEPTH-2
int_rx_thr  out  1  level interrupt, rx_count >= threshold
int_rx_tout  out  1  character timeout interrupt
overrun_err  out  1  sticky overrun flag
ovr_clr  in  1  clears overrun_err

Behaviour:
- All state updates on posedge pclk only.
- presetn=0 at a clock edge: pointers=0, rx_count=0, rx_empty=1, rx_full_status=0, int_rx_thr=0, int_rx_tout=0, overrun_err=0, pending parity=0, timeout counters=0.
- rd_data and rd_perr are 0 out of reset; storage is not cleared.
- rx_full_status = (rx_count==DEPTH); rx_empty = (rx_count==0). Both registered-state derived, no combinational path from rx_wr or rd_en.
- Write: rx_wr and not full stores {perr_tag, rx_data} at wr_ptr, then wr_ptr+1 mod DEPTH. rx_wr while full is ignored.
- Read: rd_en and not empty advances rd_ptr. rd_en while empty is ignored. rd_data/rd_perr show the new head on the next cycle.
- Simultaneous accepted read and write: both occur, rx_count unchanged. The write is accepted even at full when a read occurs in the same cycle.
- Parity tagging:
  - s_parrity_error sets perr_pend.
  - perr_tag = perr_pend OR s_parrity_error in the same cycle.
  - perr_pend clears on rx_frame_end.
- Overrun: rx_frame_end with rx_full_status=1 sets overrun_err, regardless of a same-cycle read. ovr_clr clears it; set wins over clear in the same cycle.
- Flush: fifo_flush zeroes pointers, count, perr_pend, the timeout counter and int_rx_tout. It has priority over rx_wr/rd_en that cycle. overrun_err is unaffected.
- Threshold: int_rx_thr is registered, so it updates one cycle after rx_count changes.
- Timeout:
  - Bit-tick counter counts bclk to 13 (osm_sel=1) or 16 (osm_sel=0) and emits bit_end.
  - Idle counter (saturating at TOUT_BITS) increments on bit_end while not empty.
  - Idle counter clears on accepted rx_wr, accepted rd_en, flush, or empty.
  - int_rx_tout sets when the idle counter reaches TOUT_BITS. It clears on accepted rd_en, rx_wr, or flush.
  - Bit-tick counter clears while empty.
- osm_sel change mid-count: takes effect at the next wrap. A count already past the new limit wraps at 15.

Optional Feature:
UART_RX_STATS_EN
- Defined: adds output rx_drop_cnt [7:0], incremented on each overrun event. It saturates at 255, is cleared by ovr_clr and by reset, and is not cleared by flush.
- Undefined: port and counter absent, no other change.

Decomposition:
- Package uart_rx_pkg: trigger-level encoding constants, OSM tick counts (13, 16), default DEPTH/TOUT_BITS.
- Sub-module uart_rx_fifo_mem: storage array, pointers, count, full/empty, 9-bit entries.
- uart_rx_ctrl top: parity tagging, overrun, interrupts, timeout.

Test Plan:
- Write 0x41, 0x42, 0x43, then three rd_en -> rd_data 0x41, 0x42, 0x43 in order; rx_count 3→0; rx_empty=1 after the last pop.
- Fill 16 entries, then rx_frame_end with no rx_wr -> rx_full_status=1, overrun_err=1. ovr_clr -> overrun_err=0. FIFO contents intact.
- s_parrity_error pulse, then rx_wr 0x55 -> head rd_perr=1. Next clean frame 0xAA -> rd_perr=0.
- rx_trig_lvl=01, write 4 characters -> int_rx_thr=1 one cycle after the 4th write. Pop one -> int_rx_thr=0.
- osm_sel=0, one character held unread -> int_rx_tout asserts after 40x16 bclk ticks. A rd_en clears it.
- Full FIFO, simultaneous rx_wr+rd_en -> rx_count stays 16. fifo_flush concurrent with rx_wr -> rx_count=0.
